// File: rtl/packet_gen.sv
// AXI-Stream test packet generator: emits a burst of packets carrying an
// incrementing 16-bit word pattern, with configurable length, count and gaps.
module packet_gen #(
    parameter int DW = 512
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [15:0]         packet_len,
    input  logic [31:0]         packet_count,
    input  logic [15:0]         idle_cycles,
    input  logic [15:0]         initial_value,
    input  logic                start,
    output logic                busy,
    output logic [DW-1:0]       AXIS_TX_TDATA,
    output logic [DW/8-1:0]     AXIS_TX_TKEEP,
    output logic                AXIS_TX_TLAST,
    output logic                AXIS_TX_TVALID,
    input  logic                AXIS_TX_TREADY
);

    localparam int BPB = DW / 8;
    localparam int WPB = DW / 16;
    localparam int RW  = (BPB > 1) ? $clog2(BPB) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t            r_state;
    logic              r_busy;
    logic [DW-1:0]     r_tdata;
    logic [BPB-1:0]    r_tkeep;
    logic              r_tlast;
    logic              r_tvalid;
    logic [15:0]       r_value;
    logic [15:0]       r_beat;
    logic [15:0]       r_nb;
    logic [RW-1:0]     r_rem;
    logic [31:0]       r_pkts;
    logic [15:0]       r_idle;
    logic [15:0]       r_gap;

    logic [15:0]       w_len_eff;
    logic [16:0]       w_len_round;
    logic [15:0]       w_nb_in;
    logic [RW-1:0]     w_rem_in;
    logic [15:0]       w_next_value;
    logic              w_accept;
    logic              w_first_last;
    logic              w_next_last;

    // A zero length is generated as a single one-byte beat.
    assign w_len_eff    = (packet_len == 16'd0) ? 16'd1 : packet_len;
    assign w_len_round  = {1'b0, w_len_eff} + 17'(BPB - 1);
    assign w_nb_in      = 16'(w_len_round / 17'(BPB));
    assign w_rem_in     = RW'(w_len_eff % 16'(BPB));

    assign w_next_value = r_value + 16'(WPB);
    assign w_accept     = r_tvalid && AXIS_TX_TREADY;
    assign w_first_last = (r_nb == 16'd1);
    assign w_next_last  = ((r_beat + 16'd2) == r_nb);

    function automatic logic [DW-1:0] beat_data(input logic [15:0] v);
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < WPB; k++) begin
            d[16*k +: 16] = v + 16'(k);
        end
        return d;
    endfunction

    function automatic logic [BPB-1:0] beat_keep(input logic last, input logic [RW-1:0] rem);
        logic [BPB-1:0] kp;
        kp = '0;
        for (int b = 0; b < BPB; b++) begin
            kp[b] = !last || (rem == '0) || (b < int'(rem));
        end
        return kp;
    endfunction

    // Output beat registers are reloaded only on acceptance or when a packet
    // starts, so they hold steady while the sink stalls.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
            r_value  <= 16'd0;
            r_beat   <= 16'd0;
            r_nb     <= 16'd1;
            r_rem    <= '0;
            r_pkts   <= 32'd0;
            r_idle   <= 16'd0;
            r_gap    <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_busy   <= 1'b0;
                    r_tvalid <= 1'b0;
                    if (start) begin
                        r_nb    <= w_nb_in;
                        r_rem   <= w_rem_in;
                        r_pkts  <= packet_count;
                        r_idle  <= idle_cycles;
                        r_value <= initial_value;
                        r_beat  <= 16'd0;
                        if (packet_count != 32'd0) begin
                            r_state  <= S_SEND;
                            r_busy   <= 1'b1;
                            r_tvalid <= 1'b1;
                            r_tdata  <= beat_data(initial_value);
                            r_tlast  <= (w_nb_in == 16'd1);
                            r_tkeep  <= beat_keep(w_nb_in == 16'd1, w_rem_in);
                        end
                    end
                end

                S_SEND: begin
                    if (w_accept) begin
                        r_value <= w_next_value;
                        if (r_tlast) begin
                            r_pkts <= r_pkts - 32'd1;
                            if (r_pkts == 32'd1) begin
                                r_state  <= S_IDLE;
                                r_busy   <= 1'b0;
                                r_tvalid <= 1'b0;
                                r_tlast  <= 1'b0;
                                r_tdata  <= '0;
                                r_tkeep  <= '0;
                            end else if (r_idle != 16'd0) begin
                                r_state  <= S_GAP;
                                r_tvalid <= 1'b0;
                                r_tlast  <= 1'b0;
                                r_gap    <= r_idle;
                            end else begin
                                r_beat  <= 16'd0;
                                r_tdata <= beat_data(w_next_value);
                                r_tlast <= w_first_last;
                                r_tkeep <= beat_keep(w_first_last, r_rem);
                            end
                        end else begin
                            r_beat  <= r_beat + 16'd1;
                            r_tdata <= beat_data(w_next_value);
                            r_tlast <= w_next_last;
                            r_tkeep <= beat_keep(w_next_last, r_rem);
                        end
                    end
                end

                S_GAP: begin
                    // r_gap counts the remaining tvalid-low cycles, including this one.
                    if (r_gap == 16'd1) begin
                        r_state  <= S_SEND;
                        r_tvalid <= 1'b1;
                        r_beat   <= 16'd0;
                        r_tdata  <= beat_data(r_value);
                        r_tlast  <= w_first_last;
                        r_tkeep  <= beat_keep(w_first_last, r_rem);
                    end else begin
                        r_gap <= r_gap - 16'd1;
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_tvalid <= 1'b0;
                    r_tlast  <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign AXIS_TX_TDATA  = r_tdata;
    assign AXIS_TX_TKEEP  = r_tkeep;
    assign AXIS_TX_TLAST  = r_tlast;
    assign AXIS_TX_TVALID = r_tvalid;

endmodule

// File: tb/tb_packet_gen.sv
// Directed bench for packet_gen (DW=512): reset, single/gapped/back-to-back
// bursts, pattern wrap, random backpressure, mid-burst reset and ignored starts.
module tb_packet_gen;

    localparam int DW = 512;
    localparam logic [63:0] ALL1 = '1;

    logic           clk;
    logic           resetn;
    logic [15:0]    packetLen;
    logic [31:0]    packetCount;
    logic [15:0]    idleCycles;
    logic [15:0]    initialValue;
    logic           start;
    logic           busy;
    logic [DW-1:0]  tdata;
    logic [63:0]    tkeep;
    logic           tlast;
    logic           tvalid;
    logic           tready;

    int nChecks = 0;
    int nFails  = 0;

    packet_gen #(.DW(DW)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .packet_len     (packetLen),
        .packet_count   (packetCount),
        .idle_cycles    (idleCycles),
        .initial_value  (initialValue),
        .start          (start),
        .busy           (busy),
        .AXIS_TX_TDATA  (tdata),
        .AXIS_TX_TKEEP  (tkeep),
        .AXIS_TX_TLAST  (tlast),
        .AXIS_TX_TVALID (tvalid),
        .AXIS_TX_TREADY (tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives the config and a one-cycle start pulse; returns at the negedge
    // where the first beat should be visible.
    task automatic pulse_start(input logic [15:0] len, input logic [31:0] cnt,
                               input logic [15:0] idle, input logic [15:0] init);
        @(negedge clk);
        packetLen = len; packetCount = cnt; idleCycles = idle; initialValue = init;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        nChecks++; if (tvalid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_tvalid: got %b expected 0", tvalid); end
        nChecks++; if (tlast !== 1'b0) begin nFails++; $display("[TB] FAIL reset_tlast: got %b expected 0", tlast); end
        nChecks++; if (tdata !== '0) begin nFails++; $display("[TB] FAIL reset_tdata: got %h expected 0", tdata[63:0]); end
        nChecks++; if (tkeep !== 64'd0) begin nFails++; $display("[TB] FAIL reset_tkeep: got %h expected 0", tkeep); end
        nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        tready = 1'b1;
        pulse_start(16'd256, 32'd1, 16'd1, 16'h0000);
        for (int b = 0; b < 4; b++) begin
            nChecks++; if (tvalid !== 1'b1) begin nFails++; $display("[TB] FAIL single_tvalid b%0d: got %b expected 1", b, tvalid); end
            nChecks++; if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL single_busy b%0d: got %b expected 1", b, busy); end
            nChecks++; if (tkeep !== ALL1) begin nFails++; $display("[TB] FAIL single_tkeep b%0d: got %h expected %h", b, tkeep, ALL1); end
            nChecks++; if (tlast !== (b == 3)) begin nFails++; $display("[TB] FAIL single_tlast b%0d: got %b expected %b", b, tlast, (b == 3)); end
            nChecks++; if (tdata[15:0] !== 16'(b * 32)) begin nFails++; $display("[TB] FAIL single_word0 b%0d: got %h expected %h", b, tdata[15:0], 16'(b * 32)); end
            nChecks++; if (tdata[16*31 +: 16] !== 16'(b * 32 + 31)) begin nFails++; $display("[TB] FAIL single_word31 b%0d: got %h expected %h", b, tdata[16*31 +: 16], 16'(b * 32 + 31)); end
            @(negedge clk);
        end
        nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL single_busy_end: got %b expected 0", busy); end
        nChecks++; if (tvalid !== 1'b0) begin nFails++; $display("[TB] FAIL single_tvalid_end: got %b expected 0", tvalid); end
    endtask

    task automatic test_gap();
        logic [63:0] keep36;
        keep36 = 64'h0000_000F_FFFF_FFFF;
        tready = 1'b1;
        pulse_start(16'd100, 32'd2, 16'd3, 16'h0000);
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < 2; b++) begin
                nChecks++; if (tvalid !== 1'b1) begin nFails++; $display("[TB] FAIL gap_tvalid p%0d b%0d: got %b expected 1", p, b, tvalid); end
                nChecks++; if (tdata[15:0] !== 16'(64 * p + 32 * b)) begin nFails++; $display("[TB] FAIL gap_word0 p%0d b%0d: got %h expected %h", p, b, tdata[15:0], 16'(64 * p + 32 * b)); end
                nChecks++; if (tkeep !== ((b == 1) ? keep36 : ALL1)) begin nFails++; $display("[TB] FAIL gap_tkeep p%0d b%0d: got %h expected %h", p, b, tkeep, ((b == 1) ? keep36 : ALL1)); end
                nChecks++; if (tlast !== (b == 1)) begin nFails++; $display("[TB] FAIL gap_tlast p%0d b%0d: got %b expected %b", p, b, tlast, (b == 1)); end
                @(negedge clk);
            end
            if (p == 0) begin
                for (int g = 0; g < 3; g++) begin
                    nChecks++; if (tvalid !== 1'b0) begin nFails++; $display("[TB] FAIL gap_idle g%0d: got tvalid %b expected 0", g, tvalid); end
                    nChecks++; if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL gap_busy g%0d: got %b expected 1", g, busy); end
                    @(negedge clk);
                end
            end
        end
        nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL gap_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        tready = 1'b1;
        pulse_start(16'd64, 32'd3, 16'd0, 16'h0100);
        for (int p = 0; p < 3; p++) begin
            nChecks++; if (tvalid !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_tvalid p%0d: got %b expected 1", p, tvalid); end
            nChecks++; if (tlast !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_tlast p%0d: got %b expected 1", p, tlast); end
            nChecks++; if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_busy p%0d: got %b expected 1", p, busy); end
            nChecks++; if (tkeep !== ALL1) begin nFails++; $display("[TB] FAIL b2b_tkeep p%0d: got %h expected %h", p, tkeep, ALL1); end
            nChecks++; if (tdata[15:0] !== 16'(16'h0100 + 32 * p)) begin nFails++; $display("[TB] FAIL b2b_word0 p%0d: got %h expected %h", p, tdata[15:0], 16'(16'h0100 + 32 * p)); end
            @(negedge clk);
        end
        nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_busy_end: got %b expected 0", busy); end
        nChecks++; if (tvalid !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_tvalid_end: got %b expected 0", tvalid); end
    endtask

    task automatic test_wrap();
        tready = 1'b1;
        pulse_start(16'd64, 32'd1, 16'd0, 16'hFFF0);
        nChecks++; if (tdata[15:0] !== 16'hFFF0) begin nFails++; $display("[TB] FAIL wrap_word0: got %h expected fff0", tdata[15:0]); end
        nChecks++; if (tdata[16*15 +: 16] !== 16'hFFFF) begin nFails++; $display("[TB] FAIL wrap_word15: got %h expected ffff", tdata[16*15 +: 16]); end
        nChecks++; if (tdata[16*16 +: 16] !== 16'h0000) begin nFails++; $display("[TB] FAIL wrap_word16: got %h expected 0000", tdata[16*16 +: 16]); end
        nChecks++; if (tdata[16*31 +: 16] !== 16'h000F) begin nFails++; $display("[TB] FAIL wrap_word31: got %h expected 000f", tdata[16*31 +: 16]); end
        @(negedge clk);
    endtask

    task automatic test_short();
        tready = 1'b1;
        pulse_start(16'd0, 32'd1, 16'd0, 16'hABCD);
        nChecks++; if (tvalid !== 1'b1) begin nFails++; $display("[TB] FAIL short_tvalid: got %b expected 1", tvalid); end
        nChecks++; if (tlast !== 1'b1) begin nFails++; $display("[TB] FAIL short_tlast: got %b expected 1", tlast); end
        nChecks++; if (tkeep !== 64'h1) begin nFails++; $display("[TB] FAIL short_tkeep: got %h expected 1", tkeep); end
        nChecks++; if (tdata[15:0] !== 16'hABCD) begin nFails++; $display("[TB] FAIL short_word0: got %h expected abcd", tdata[15:0]); end
        @(negedge clk);
        nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL short_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_stall();
        logic [DW-1:0] pData;
        logic [63:0]   pKeep;
        logic          pLast;
        logic          pStall;
        logic          rdy;
        logic [15:0]   ev;
        int beat, pkt, accepted, cyc;
        pStall = 1'b0; pData = '0; pKeep = '0; pLast = 1'b0;
        beat = 0; pkt = 0; accepted = 0; cyc = 0; ev = 16'h1234;
        tready = 1'b0;
        pulse_start(16'd9600, 32'd4, 16'd2, 16'h1234);
        while (pkt < 4 && cyc < 6000) begin
            if (pStall) begin
                nChecks++; if (tvalid !== 1'b1) begin nFails++; $display("[TB] FAIL stall_tvalid_drop cyc%0d: got %b expected 1", cyc, tvalid); end
                nChecks++; if (tdata !== pData) begin nFails++; $display("[TB] FAIL stall_tdata cyc%0d: got %h expected %h", cyc, tdata[63:0], pData[63:0]); end
                nChecks++; if (tkeep !== pKeep || tlast !== pLast) begin nFails++; $display("[TB] FAIL stall_ctrl cyc%0d: got %h/%b expected %h/%b", cyc, tkeep, tlast, pKeep, pLast); end
            end
            if (tvalid === 1'b1) begin
                nChecks++; if (tdata[15:0] !== ev || tdata[16*31 +: 16] !== 16'(ev + 16'd31)) begin nFails++; $display("[TB] FAIL stall_data p%0d b%0d: got %h/%h expected %h/%h", pkt, beat, tdata[15:0], tdata[16*31 +: 16], ev, 16'(ev + 16'd31)); end
                nChecks++; if (tlast !== (beat == 149)) begin nFails++; $display("[TB] FAIL stall_tlast p%0d b%0d: got %b expected %b", pkt, beat, tlast, (beat == 149)); end
                nChecks++; if (tkeep !== ALL1) begin nFails++; $display("[TB] FAIL stall_tkeep p%0d b%0d: got %h expected %h", pkt, beat, tkeep, ALL1); end
            end
            rdy = 1'($urandom_range(0, 1));
            tready = rdy;
            if (tvalid === 1'b1 && rdy) begin
                ev = ev + 16'd32;
                accepted++;
                if (beat == 149) begin beat = 0; pkt++; end
                else beat++;
            end
            pStall = (tvalid === 1'b1) && !rdy;
            pData = tdata; pKeep = tkeep; pLast = tlast;
            @(negedge clk);
            cyc++;
        end
        tready = 1'b1;
        nChecks++; if (cyc >= 6000) begin nFails++; $display("[TB] FAIL stall_timeout: got %0d packets expected 4", pkt); end
        nChecks++; if (accepted != 600) begin nFails++; $display("[TB] FAIL stall_beats: got %0d expected 600", accepted); end
        nChecks++; if (busy !== 1'b0 || tvalid !== 1'b0) begin nFails++; $display("[TB] FAIL stall_end: got busy %b tvalid %b expected 0/0", busy, tvalid); end
    endtask

    task automatic test_reset_mid();
        tready = 1'b1;
        pulse_start(16'd256, 32'd5, 16'd0, 16'h0000);
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        nChecks++; if (tvalid !== 1'b0) begin nFails++; $display("[TB] FAIL rstmid_tvalid: got %b expected 0", tvalid); end
        nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
        nChecks++; if (tlast !== 1'b0) begin nFails++; $display("[TB] FAIL rstmid_tlast: got %b expected 0", tlast); end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        nChecks++; if (busy !== 1'b0 || tvalid !== 1'b0) begin nFails++; $display("[TB] FAIL rstmid_resume: got busy %b tvalid %b expected 0/0", busy, tvalid); end
    endtask

    task automatic test_start_ignored();
        tready = 1'b1;
        pulse_start(16'd64, 32'd2, 16'd0, 16'h0000);
        nChecks++; if (tdata[15:0] !== 16'h0000 || tlast !== 1'b1) begin nFails++; $display("[TB] FAIL ign_beat0: got %h/%b expected 0000/1", tdata[15:0], tlast); end
        packetLen = 16'd128; packetCount = 32'd10; idleCycles = 16'd5; initialValue = 16'h5000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nChecks++; if (tdata[15:0] !== 16'h0020 || tlast !== 1'b1 || tvalid !== 1'b1) begin nFails++; $display("[TB] FAIL ign_beat1: got %h/%b/%b expected 0020/1/1", tdata[15:0], tlast, tvalid); end
        @(negedge clk);
        nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL ign_busy_end: got %b expected 0", busy); end
        @(negedge clk);
        nChecks++; if (busy !== 1'b0 || tvalid !== 1'b0) begin nFails++; $display("[TB] FAIL ign_no_restart: got busy %b tvalid %b expected 0/0", busy, tvalid); end
    endtask

    task automatic test_count_zero();
        tready = 1'b1;
        pulse_start(16'd64, 32'd0, 16'd0, 16'h0000);
        for (int c = 0; c < 3; c++) begin
            nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL zero_busy c%0d: got %b expected 0", c, busy); end
            nChecks++; if (tvalid !== 1'b0) begin nFails++; $display("[TB] FAIL zero_tvalid c%0d: got %b expected 0", c, tvalid); end
            @(negedge clk);
        end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; tready = 1'b1;
        packetLen = 16'd0; packetCount = 32'd0; idleCycles = 16'd0; initialValue = 16'd0;
        test_reset();
        test_single();
        test_gap();
        test_back_to_back();
        test_wrap();
        test_short();
        test_stall();
        test_reset_mid();
        test_start_ignored();
        test_count_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
